// File: rtl/gmii_tx_framer.sv
// Transmit GMII framer: drains a FWFT MAC FIFO and emits preamble/SFD, payload,
// zero padding, CRC-32 FCS and the inter-frame gap on the PHY transmit pins.
module gmii_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_BYTES    = 12
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    output logic        rd_en,
    input  logic [8:0]  rd_data,
    input  logic        rd_empty,
    output logic        phy_tx_en,
    output logic        phy_tx_er,
    output logic [7:0]  phy_txd,
    output logic        busy,
    output logic [31:0] tx_frames,
    output logic [15:0] tx_underruns
);

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;

    typedef enum logic [2:0] {
        IDLE, PRE, SFD, DATA, PAD, FCS, DRAIN, IFG
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [10:0] byte_cnt;
    logic [31:0] crc;
    logic [10:0] byte_cnt_inc;
    logic [31:0] fcs_word;
    logic [7:0]  fcs_byte;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in;
        for (int unsigned i = 0; i < 8; i++)
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        return c;
    endfunction

    always_comb begin
        rd_en        = !sys_rst && !rd_empty && ((state == DATA) || (state == DRAIN));
        byte_cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
        fcs_word     = ~crc;
        case (cnt[1:0])
            2'd0:    fcs_byte = fcs_word[7:0];
            2'd1:    fcs_byte = fcs_word[15:8];
            2'd2:    fcs_byte = fcs_word[23:16];
            default: fcs_byte = fcs_word[31:24];
        endcase
    end

    // Each state decides the byte registered onto the pins at the next edge,
    // so the SFD state launches 0xD5 while DATA pops immediately after it.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            byte_cnt     <= '0;
            crc          <= '1;
            phy_tx_en    <= 1'b0;
            phy_tx_er    <= 1'b0;
            phy_txd      <= '0;
            busy         <= 1'b0;
            tx_frames    <= '0;
            tx_underruns <= '0;
        end else begin
            phy_tx_en <= 1'b0;
            phy_tx_er <= 1'b0;
            phy_txd   <= '0;
            case (state)
                IDLE: begin
                    if (!rd_empty) begin
                        phy_tx_en <= 1'b1;
                        phy_txd   <= 8'h55;
                        busy      <= 1'b1;
                        cnt       <= 16'd1;
                        state     <= (PREAMBLE_LEN > 1) ? PRE : SFD;
                    end
                end
                PRE: begin
                    phy_tx_en <= 1'b1;
                    phy_txd   <= 8'h55;
                    cnt       <= cnt + 16'd1;
                    if (cnt == 16'(PREAMBLE_LEN - 1))
                        state <= SFD;
                end
                SFD: begin
                    phy_tx_en <= 1'b1;
                    phy_txd   <= 8'hD5;
                    crc       <= '1;
                    byte_cnt  <= '0;
                    state     <= DATA;
                end
                DATA: begin
                    phy_tx_en <= 1'b1;
                    if (!rd_empty) begin
                        phy_txd  <= rd_data[7:0];
                        crc      <= crc32_byte(crc, rd_data[7:0]);
                        byte_cnt <= byte_cnt_inc;
                        if (rd_data[8]) begin
                            cnt   <= '0;
                            state <= (byte_cnt_inc < 11'(MIN_FRAME)) ? PAD : FCS;
                        end
                    end else begin
                        phy_tx_er <= 1'b1;
                        if (tx_underruns != '1)
                            tx_underruns <= tx_underruns + 16'd1;
                        state <= DRAIN;
                    end
                end
                PAD: begin
                    phy_tx_en <= 1'b1;
                    crc       <= crc32_byte(crc, 8'h00);
                    byte_cnt  <= byte_cnt_inc;
                    if (byte_cnt_inc == 11'(MIN_FRAME))
                        state <= FCS;
                end
                FCS: begin
                    phy_tx_en <= 1'b1;
                    phy_txd   <= fcs_byte;
                    cnt       <= cnt + 16'd1;
                    if (cnt[1:0] == 2'd3) begin
                        tx_frames <= tx_frames + 32'd1;
                        cnt       <= '0;
                        state     <= IFG;
                    end
                end
                DRAIN: begin
                    if (!rd_empty && rd_data[8]) begin
                        cnt   <= '0;
                        state <= IFG;
                    end
                end
                IFG: begin
                    cnt <= cnt + 16'd1;
                    if (cnt == 16'(IFG_BYTES - 1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
